// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the 64-to-16 FIFO read-side drain engine.
package fifo_rd_pkg;

  localparam int BEATS_PER_WORD = 4;

  typedef logic [1:0]  beat_idx_t;
  typedef logic [63:0] word_t;

endpackage

// File: rtl/fifo_rd_wordbuf.sv
// Two-entry 64-bit word buffer with push, pop and occupancy count.
module fifo_rd_wordbuf
  import fifo_rd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  word_t      push_data,
  input  logic       pop,
  output word_t      head,
  output logic [1:0] count
);

  word_t      mem_q [0:1];
  word_t      mem_d [0:1];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;

  // Push and pop in the same cycle leave the count unchanged while the head advances.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/fifo_rd_stream_64to16.sv
// FIFO read drain: credit-based rd_en issue, read-latency tracking and 64-to-16 serializer.
// Build option FIFO_RD_MSB_FIRST_EN emits the most significant halfword of each word first.
module fifo_rd_stream_64to16
  import fifo_rd_pkg::*;
#(
  parameter int c_RD_DATA_WIDTH = 64,
  parameter int c_OUT_WIDTH     = 16,
  parameter int c_RD_LATENCY    = 1,
  parameter int c_CNT_WIDTH     = 16
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst_n,
  output logic                       rd_en,
  output logic                       rd_oce,
  input  logic                       rd_empty,
  input  logic [c_RD_DATA_WIDTH-1:0] rd_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [c_OUT_WIDTH-1:0]     o_data,
  output logic                       o_last,
  output logic [c_CNT_WIDTH-1:0]     o_word_cnt,
  output logic                       busy
);

  // Output stream: a beat moves on a cycle where o_valid && o_ready; once o_valid
  // rises, o_valid, o_data and o_last hold until that beat has been accepted.

  logic [c_RD_LATENCY-1:0] lat_q, lat_d;
  beat_idx_t               beat_idx_q, beat_idx_d;
  logic [c_CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;

  logic [1:0] buf_cnt;
  logic [1:0] inflight;
  logic [2:0] credit_sum;
  word_t      head;
  logic       capture;
  logic       xfer;
  logic       pop;
  beat_idx_t  sel;

  fifo_rd_wordbuf u_wordbuf (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (capture),
    .push_data (rd_data),
    .pop       (pop),
    .head      (head),
    .count     (buf_cnt)
  );

  always_comb begin
    inflight = 2'd0;
    for (int i = 0; i < c_RD_LATENCY; i++) begin
      inflight = inflight + {1'b0, lat_q[i]};
    end
  end

  // Credits use registered occupancy only, so a pop this cycle frees its slot next cycle.
  assign credit_sum = {1'b0, buf_cnt} + {1'b0, inflight};
  assign rd_en      = !rd_empty && (credit_sum < 3'd2);
  assign rd_oce     = 1'b1;
  assign capture    = lat_q[c_RD_LATENCY-1];

  assign o_valid = (buf_cnt != 2'd0);
  assign xfer    = o_valid && o_ready;
  assign pop     = xfer && (beat_idx_q == beat_idx_t'(BEATS_PER_WORD - 1));
  assign o_last  = (beat_idx_q == beat_idx_t'(BEATS_PER_WORD - 1));

`ifdef FIFO_RD_MSB_FIRST_EN
  assign sel = ~beat_idx_q;
`else
  assign sel = beat_idx_q;
`endif

  assign o_data     = o_valid ? head[int'(sel)*c_OUT_WIDTH +: c_OUT_WIDTH] : '0;
  assign o_word_cnt = word_cnt_q;
  assign busy       = (buf_cnt != 2'd0) || (inflight != 2'd0);

  always_comb begin
    lat_d      = lat_q;
    beat_idx_d = beat_idx_q;
    word_cnt_d = word_cnt_q;
    lat_d[0] = rd_en;
    for (int i = 1; i < c_RD_LATENCY; i++) begin
      lat_d[i] = lat_q[i-1];
    end
    if (xfer) begin
      beat_idx_d = beat_idx_q + 2'd1;
    end
    if (pop) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      lat_q      <= '0;
      beat_idx_q <= '0;
      word_cnt_q <= '0;
    end else begin
      lat_q      <= lat_d;
      beat_idx_q <= beat_idx_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_64to16.sv
// Directed bench: instance a (latency 2, 16-bit counter) and instance b (latency 1, 4-bit counter).
module tb_fifo_rd_stream_64to16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- instance a ----------------
  logic        rd_en_a, rd_oce_a, rd_empty_a, o_valid_a, o_ready_a, o_last_a, busy_a;
  logic [63:0] rd_data_a, pipe_a;
  logic [15:0] o_data_a, o_word_cnt_a;
  logic [63:0] fq_a[$];
  logic [15:0] exp_a[$];
  int          issued_a, popped_a;
  logic [1:0]  pos_a;
  logic        stall_a, hold_last_a;
  logic [15:0] hold_data_a;

  fifo_rd_stream_64to16 #(.c_RD_DATA_WIDTH(64), .c_OUT_WIDTH(16), .c_RD_LATENCY(2), .c_CNT_WIDTH(16)) u_dut_a (
    .rd_clk(clk), .rd_rst_n(rst_n), .rd_en(rd_en_a), .rd_oce(rd_oce_a), .rd_empty(rd_empty_a),
    .rd_data(rd_data_a), .o_valid(o_valid_a), .o_ready(o_ready_a), .o_data(o_data_a),
    .o_last(o_last_a), .o_word_cnt(o_word_cnt_a), .busy(busy_a)
  );

  // ---------------- instance b ----------------
  logic        rd_en_b, rd_oce_b, rd_empty_b, o_valid_b, o_ready_b, o_last_b, busy_b;
  logic [63:0] rd_data_b;
  logic [15:0] o_data_b;
  logic [3:0]  o_word_cnt_b;
  logic [63:0] fq_b[$];
  logic [15:0] exp_b[$];
  int          issued_b, popped_b;
  logic [1:0]  pos_b;

  fifo_rd_stream_64to16 #(.c_RD_DATA_WIDTH(64), .c_OUT_WIDTH(16), .c_RD_LATENCY(1), .c_CNT_WIDTH(4)) u_dut_b (
    .rd_clk(clk), .rd_rst_n(rst_n), .rd_en(rd_en_b), .rd_oce(rd_oce_b), .rd_empty(rd_empty_b),
    .rd_data(rd_data_b), .o_valid(o_valid_b), .o_ready(o_ready_b), .o_data(o_data_b),
    .o_last(o_last_b), .o_word_cnt(o_word_cnt_b), .busy(busy_b)
  );

  // FIFO models: registered empty flag, read data after 2 (a) or 1 (b) cycles.
  always @(posedge clk or negedge rst_n) begin : fifo_model_a
    logic [63:0] w;
    if (!rst_n) begin
      fq_a.delete();
      rd_empty_a <= 1'b1;
      pipe_a     <= '0;
      rd_data_a  <= '0;
    end else begin
      w = '0;
      if (rd_en_a && fq_a.size() != 0) w = fq_a.pop_front();
      pipe_a     <= w;
      rd_data_a  <= pipe_a;
      rd_empty_a <= (fq_a.size() == 0);
    end
  end

  always @(posedge clk or negedge rst_n) begin : fifo_model_b
    logic [63:0] w;
    if (!rst_n) begin
      fq_b.delete();
      rd_empty_b <= 1'b1;
      rd_data_b  <= '0;
    end else begin
      w = '0;
      if (rd_en_b && fq_b.size() != 0) w = fq_b.pop_front();
      rd_data_b  <= w;
      rd_empty_b <= (fq_b.size() == 0);
    end
  end

  // Scoreboards, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_a.delete();
      issued_a = 0; popped_a = 0; pos_a = 2'd0; stall_a = 1'b0;
    end else begin
      if (rd_en_a) begin
        chk("rd_en_while_empty_a", rd_empty_a, 1'b0);
        chk("credit_a", (issued_a - popped_a) < 2, 1'b1);
        issued_a++;
      end
      if (stall_a) begin
        chk("hold_valid_a", o_valid_a, 1'b1);
        chk("hold_data_a", o_data_a, hold_data_a);
        chk("hold_last_a", o_last_a, hold_last_a);
      end
      if (o_valid_a && o_ready_a) begin
        if (exp_a.size() == 0) chk("extra_beat_a", 1'b1, 1'b0);
        else chk("beat_a", o_data_a, exp_a.pop_front());
        chk("last_a", o_last_a, pos_a == 2'd3);
        if (pos_a == 2'd3) popped_a++;
        pos_a = pos_a + 2'd1;
      end
      stall_a     = o_valid_a && !o_ready_a;
      hold_data_a = o_data_a;
      hold_last_a = o_last_a;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_b.delete();
      issued_b = 0; popped_b = 0; pos_b = 2'd0;
    end else begin
      if (rd_en_b) begin
        chk("rd_en_while_empty_b", rd_empty_b, 1'b0);
        chk("credit_b", (issued_b - popped_b) < 2, 1'b1);
        issued_b++;
      end
      if (o_valid_b && o_ready_b) begin
        if (exp_b.size() == 0) chk("extra_beat_b", 1'b1, 1'b0);
        else chk("beat_b", o_data_b, exp_b.pop_front());
        chk("last_b", o_last_b, pos_b == 2'd3);
        if (pos_b == 2'd3) popped_b++;
        pos_b = pos_b + 2'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [63:0] w);
    fq_a.push_back(w);
`ifdef FIFO_RD_MSB_FIRST_EN
    for (int i = 3; i >= 0; i--) exp_a.push_back(w[i*16 +: 16]);
`else
    for (int i = 0; i < 4; i++) exp_a.push_back(w[i*16 +: 16]);
`endif
  endtask

  task automatic push_b(input logic [63:0] w);
    fq_b.push_back(w);
`ifdef FIFO_RD_MSB_FIRST_EN
    for (int i = 3; i >= 0; i--) exp_b.push_back(w[i*16 +: 16]);
`else
    for (int i = 0; i < 4; i++) exp_b.push_back(w[i*16 +: 16]);
`endif
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    while ((busy_a || exp_a.size() != 0 || fq_a.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_budget_a", n < budget, 1'b1);
  endtask

  task automatic wait_idle_b(input int budget);
    int n = 0;
    while ((busy_b || exp_b.size() != 0 || fq_b.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_budget_b", n < budget, 1'b1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_rd_en"}, rd_en_a, 1'b0);
    chk({tag, "_rd_oce"}, rd_oce_a, 1'b1);
    chk({tag, "_valid"}, o_valid_a, 1'b0);
    chk({tag, "_data"}, o_data_a, 16'h0);
    chk({tag, "_last"}, o_last_a, 1'b0);
    chk({tag, "_cnt"}, o_word_cnt_a, 16'h0);
    chk({tag, "_busy"}, busy_a, 1'b0);
  endtask

  // Counts falling edges from the first one showing rd_en until o_valid appears.
  task automatic measure_latency_a(output int lat);
    int n = 0;
    while (!rd_en_a && n < 20) begin @(negedge clk); n++; end
    chk("rd_en_seen_a", rd_en_a, 1'b1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (o_valid_a) begin lat = i; break; end
    end
  endtask

  task automatic measure_latency_b(output int lat);
    int n = 0;
    while (!rd_en_b && n < 20) begin @(negedge clk); n++; end
    chk("rd_en_seen_b", rd_en_b, 1'b1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (o_valid_b) begin lat = i; break; end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, run, n, iss0;
    o_ready_a = 1'b1;
    o_ready_b = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_a("reset");
    chk("reset_valid_b", o_valid_b, 1'b0);
    chk("reset_cnt_b", o_word_cnt_b, 4'h0);
    chk("reset_busy_b", busy_b, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic read, latency 2: valid three cycles after rd_en.
    iss0 = issued_a;
    push_a(64'h4444_3333_2222_1111);
    measure_latency_a(lat);
    chk("latency_a", lat, 3);
    chk("busy_during_a", busy_a, 1'b1);
    wait_idle_a(50);
    chk("basic_cnt_a", o_word_cnt_a, 16'd1);
    chk("basic_rd_en_pulses_a", issued_a - iss0, 1);
    chk("basic_busy_after_a", busy_a, 1'b0);

    // Streaming 100 words with o_ready high: 400 back-to-back valid cycles.
    tick();
    for (int i = 0; i < 100; i++) push_a({$urandom(), $urandom()});
    n = 0;
    while (!o_valid_a && n < 20) begin @(negedge clk); n++; end
    run = 0;
    while (o_valid_a && run < 1000) begin run++; @(negedge clk); end
    chk("stream_run_a", run, 400);
    chk("stream_busy_fall_a", busy_a, 1'b0);
    chk("stream_cnt_a", o_word_cnt_a, 16'd101);
    wait_idle_a(20);

    // Backpressure: random o_ready across 50 words.
    tick();
    for (int i = 0; i < 50; i++) push_a({$urandom(), $urandom()});
    n = 0;
    while ((busy_a || exp_a.size() != 0 || fq_a.size() != 0) && n < 3000) begin
      tick();
      o_ready_a = 1'($urandom_range(0, 1));
      n++;
    end
    chk("bp_in_budget_a", n < 3000, 1'b1);
    o_ready_a = 1'b1;
    chk("bp_cnt_a", o_word_cnt_a, 16'd151);

    // Single word: empty flag rises the cycle after rd_en with the read in flight.
    tick();
    iss0 = issued_a;
    push_a(64'hfeed_beef_cafe_0123);
    wait_idle_a(50);
    repeat (5) @(negedge clk);
    chk("flight_rd_en_pulses_a", issued_a - iss0, 1);
    chk("flight_cnt_a", o_word_cnt_a, 16'd152);

    // Reset in the middle of a word.
    tick();
    push_a(64'h8888_7777_6666_5555);
    push_a(64'h9999_9999_9999_9999);
    n = 0;
    while (pos_a != 2'd2 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #2;
    chk("mid_word_valid_a", o_valid_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_a("async_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    push_a(64'hdddd_cccc_bbbb_aaaa);
    wait_idle_a(50);
    chk("post_reset_cnt_a", o_word_cnt_a, 16'd1);
    chk("post_reset_pos_a", pos_a, 2'd0);

    // Instance b, latency 1: basic word then 16 more to wrap the 4-bit counter.
    tick();
    push_b(64'h4444_3333_2222_1111);
    measure_latency_b(lat);
    chk("latency_b", lat, 2);
    wait_idle_b(50);
    chk("basic_cnt_b", o_word_cnt_b, 4'd1);
    tick();
    for (int i = 0; i < 16; i++) push_b({$urandom(), $urandom()});
    n = 0;
    while (!o_valid_b && n < 20) begin @(negedge clk); n++; end
    run = 0;
    while (o_valid_b && run < 1000) begin run++; @(negedge clk); end
    chk("stream_run_b", run, 64);
    wait_idle_b(20);
    chk("wrap_cnt_b", o_word_cnt_b, 4'd1);
    chk("busy_after_b", busy_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
